scan_mux: RTL and testbench

Parametrised, registered N-to-1 channel selector for routing ring-oscillator and other asynchronous user-area signals to a single observation pin. Supports host-controlled manual selection via a valid/ready handshake and an autonomous scan mode that steps through all channels with a programmable dwell time. Every channel switch is followed by a blanking window so downstream counters never sample a channel-switch runt pulse. Sits between the oscillator bank and the GPIO/LA output path.

---
 rtl/scan_mux_pkg.sv | 18 +
 rtl/scan_mux_sync_2ff.sv | 25 ++
 rtl/scan_mux.sv | 146 ++++++++++++++
 tb/tb_scan_mux.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_mux_pkg.sv
// Shared types and constants for the scan_mux channel selector.
// SYNC_STAGES follows the SCAN_MUX_SYNC_EN build macro.
package scan_mux_pkg;

    typedef enum logic {
        ST_HOLD   = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

`ifdef SCAN_MUX_SYNC_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 0;
`endif

    localparam int BCNT_W = 4;

endpackage

// File: rtl/scan_mux_sync_2ff.sv
// Single-bit two-flop synchroniser, async active-low reset to 0.
// Used per channel by scan_mux when SCAN_MUX_SYNC_EN is defined.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/scan_mux.sv
// Registered N-to-1 observation mux with manual select and scan mode.
// Build macro SCAN_MUX_SYNC_EN adds a 2-flop synchroniser per input.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int N_CH    = 16,
    parameter int SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int DWELL_W = 16,
    parameter int BLANK   = 2
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic [N_CH-1:0]    data_in,
    input  logic               mode_i,
    input  logic [SEL_W-1:0]   sel_i,
    input  logic               sel_valid_i,
    output logic               sel_ready_o,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic               y_o,
    output logic [SEL_W-1:0]   ch_o,
    output logic               switch_o,
    output logic               scan_wrap_o,
    output logic               err_o
);

    localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(N_CH - 1);
    localparam logic [BCNT_W-1:0] BLANK_LAST =
        BCNT_W'((BLANK == 0) ? 0 : BLANK - 1);

    logic [N_CH-1:0] data_s;

`ifdef SCAN_MUX_SYNC_EN
    for (genvar i = 0; i < N_CH; i++) begin : g_sync
        sync_2ff u_sync (
            .clk   (wb_clk_i),
            .rst_n (wb_rst_ni),
            .d     (data_in[i]),
            .q     (data_s[i])
        );
    end
`else
    assign data_s = data_in;
`endif

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   ch_q, ch_d, nxt;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
    logic [DWELL_W-1:0] dcnt_q, dcnt_d, dwell_last;
    logic               y_q, y_d;
    logic               sw_q, sw_d;
    logic               wrap_q, wrap_d;
    logic               err_q, err_d;
    logic               go;

    assign dwell_last = (dwell_i == '0) ? '0 : dwell_i - DWELL_W'(1);
    assign sel_ready_o = (state_q == ST_HOLD) && !mode_i;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_HOLD;
            ch_q    <= '0;
            bcnt_q  <= '0;
            dcnt_q  <= '0;
            y_q     <= 1'b0;
            sw_q    <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            bcnt_q  <= bcnt_d;
            dcnt_q  <= dcnt_d;
            y_q     <= y_d;
            sw_q    <= sw_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        bcnt_d  = bcnt_q;
        dcnt_d  = dcnt_q;
        y_d     = y_q;
        sw_d    = 1'b0;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        go      = 1'b0;
        nxt     = ch_q;
        unique case (state_q)
            ST_HOLD: begin
                y_d = data_s[ch_q];
                if (mode_i) begin
                    if (N_CH > 1 && dcnt_q >= dwell_last) begin
                        go     = 1'b1;
                        dcnt_d = '0;
                        if (ch_q == CH_LAST) begin
                            nxt    = '0;
                            wrap_d = 1'b1;
                        end else begin
                            nxt = ch_q + SEL_W'(1);
                        end
                    end else begin
                        dcnt_d = dcnt_q + DWELL_W'(1);
                    end
                end else begin
                    // manual mode keeps the dwell count clear for re-entry
                    dcnt_d = '0;
                    if (sel_valid_i && sel_ready_o) begin
                        if (32'(sel_i) >= N_CH) begin
                            err_d = 1'b1;
                        end else if (sel_i != ch_q) begin
                            go  = 1'b1;
                            nxt = sel_i;
                        end
                    end
                end
                if (go) begin
                    ch_d = nxt;
                    sw_d = 1'b1;
                    if (BLANK > 0) begin
                        state_d = ST_SETTLE;
                        bcnt_d  = '0;
                    end
                end
            end
            ST_SETTLE: begin
                dcnt_d = '0;
                if (bcnt_q == BLANK_LAST) begin
                    state_d = ST_HOLD;
                end else begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    assign y_o         = y_q;
    assign ch_o        = ch_q;
    assign switch_o    = sw_q;
    assign scan_wrap_o = wrap_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_scan_mux.sv
// Directed self-checking bench for scan_mux (16-ch and 20-ch instances).
// Latency checks follow SYNC_STAGES, so it runs with or without the macro.
module tb_scan_mux;
    import scan_mux_pkg::*;

    localparam int LAT = SYNC_STAGES + 1;

    logic        clk;
    logic        rst_n;
    logic [15:0] data;
    logic        mode;
    logic [3:0]  sel;
    logic        valid;
    logic        ready;
    logic [15:0] dwell;
    logic        y;
    logic [3:0]  ch;
    logic        sw;
    logic        wrap;
    logic        err;

    logic [19:0] data20;
    logic [4:0]  sel20;
    logic        valid20;
    logic        ready20;
    logic        y20;
    logic [4:0]  ch20;
    logic        sw20;
    logic        wrap20;
    logic        err20;

    int n_chk;
    int n_fail;
    int exp_ch;

    scan_mux #(.N_CH(16), .DWELL_W(16), .BLANK(2)) u_dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .data_in     (data),
        .mode_i      (mode),
        .sel_i       (sel),
        .sel_valid_i (valid),
        .sel_ready_o (ready),
        .dwell_i     (dwell),
        .y_o         (y),
        .ch_o        (ch),
        .switch_o    (sw),
        .scan_wrap_o (wrap),
        .err_o       (err)
    );

    scan_mux #(.N_CH(20), .DWELL_W(16), .BLANK(2)) u_dut20 (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .data_in     (data20),
        .mode_i      (1'b0),
        .sel_i       (sel20),
        .sel_valid_i (valid20),
        .sel_ready_o (ready20),
        .dwell_i     (16'd1),
        .y_o         (y20),
        .ch_o        (ch20),
        .switch_o    (sw20),
        .scan_wrap_o (wrap20),
        .err_o       (err20)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One scan step: p-1 quiet edges, then the switch edge.
    task automatic scan_step(input int p);
        exp_ch = (exp_ch + 1) % 16;
        for (int i = 0; i < p - 1; i++) begin
            tick();
            check("scan_quiet", {sw, wrap}, 0);
        end
        tick();
        check("scan_ch", ch, exp_ch);
        check("scan_sw", sw, 1);
        check("scan_wrap", wrap, (exp_ch == 0) ? 1 : 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        data    = '0;
        mode    = 1'b0;
        sel     = '0;
        valid   = 1'b0;
        dwell   = 16'd3;
        data20  = '0;
        sel20   = '0;
        valid20 = 1'b0;

        tick();
        tick();
        check("rst_y", y, 0);
        check("rst_ch", ch, 0);
        check("rst_pulses", {sw, wrap, err}, 0);
        rst_n = 1'b1;
        tick();
        check("rst_ready", ready, 1);
        check("rst_first_edge", {sw, wrap, err}, 0);

        // manual select of channel 5
        data = 16'h0020;
        repeat (4) tick();
        check("pre_y", y, 0);
        sel   = 4'd5;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        check("man_ch", ch, 5);
        check("man_sw", sw, 1);
        check("man_ready_k1", ready, 0);
        check("man_y_k1", y, 0);
        tick();
        check("man_sw_off", sw, 0);
        check("man_ready_k2", ready, 0);
        tick();
        check("man_ready_k3", ready, 1);
        check("man_y_k2", y, 0);
        tick();
        check("man_y_new", y, 1);

        // output frozen while settling onto channel 3
        sel   = 4'd3;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        data  = 16'h0000;
        check("frz_y0", y, 1);
        tick();
        check("frz_y1", y, 1);
        tick();
        check("frz_y2", y, 1);
        tick();
        check("frz_y_new", y, 0);
        check("frz_ch", ch, 3);

        // same-channel request is consumed quietly
        valid = 1'b1;
        #1;
        check("same_ready", ready, 1);
        tick();
        valid = 1'b0;
        check("same_sw", sw, 0);
        check("same_ch", ch, 3);
        check("same_ready_after", ready, 1);

        // out-of-range and in-range on the 20-channel instance
        sel20   = 5'd20;
        valid20 = 1'b1;
        tick();
        valid20 = 1'b0;
        check("oor_err", err20, 1);
        check("oor_ch", ch20, 0);
        check("oor_sw", sw20, 0);
        check("oor_ready", ready20, 1);
        tick();
        check("oor_err_off", err20, 0);
        sel20   = 5'd19;
        valid20 = 1'b1;
        tick();
        valid20 = 1'b0;
        check("ch20_19", ch20, 19);
        check("ch20_sw", sw20, 1);
        check("ch20_err", err20, 0);

        // scan, dwell 3: 5-cycle period, wrap 15 -> 0
        exp_ch = 3;
        dwell  = 16'd3;
        mode   = 1'b1;
        #1;
        check("scan_ready", ready, 0);
        scan_step(3);
        for (int s = 0; s < 13; s++) scan_step(5);
        check("scan_at_1", ch, 1);

        // dwell 0 behaves as 1: 3-cycle period
        dwell = 16'd0;
        for (int s = 0; s < 3; s++) scan_step(3);

        // drop to manual mid-settle; settle completes first
        mode  = 1'b0;
        dwell = 16'd3;
        #1;
        check("ms_ready0", ready, 0);
        tick();
        check("ms_ready1", ready, 0);
        tick();
        check("ms_ready2", ready, 1);
        check("ms_ch", ch, exp_ch);
        tick();
        mode = 1'b1;
        scan_step(3);
        check("ms_ch5", ch, 5);

        // reset while settling on channel 9
        mode = 1'b0;
        tick();
        tick();
        data = 16'hffff;
        repeat (LAT + 1) tick();
        check("pre9_y", y, 1);
        sel   = 4'd9;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        check("ch9", ch, 9);
        tick();
        check("ch9_y", y, 1);
        rst_n = 1'b0;
        data  = 16'h0000;
        #1;
        check("arst_ch", ch, 0);
        check("arst_y", y, 0);
        check("arst_pulses", {sw, wrap, err}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rel_pulses", {sw, wrap, err}, 0);
        check("rel_ready", ready, 1);
        repeat (3) tick();

        // input step on channel 0 reaches y after LAT edges
        data = 16'h0001;
        for (int i = 0; i < LAT - 1; i++) begin
            tick();
            check("lat_wait", y, 0);
        end
        tick();
        check("lat_y", y, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
